// File: rtl/vip_stream_source.sv
// FIFO-to-stream adapter: reads pixels from a normal-mode FIFO and emits a
// valid/ready stream with sof/eol/eof markers derived from run-time geometry.
module vip_stream_source #(
    parameter int DWIDTH = 24,
    parameter int CWIDTH = 11
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_valid,
    input  logic [CWIDTH-1:0] cfg_width,
    input  logic [CWIDTH-1:0] cfg_height,
    input  logic [CWIDTH-1:0] cfg_num_frame,
    output logic              cfg_error,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_q,
    output logic              fifo_rdreq,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof,
    output logic              busy,
    output logic [CWIDTH-1:0] frame_count,
    output logic              done
);

    localparam int PWIDTH = 2 * CWIDTH;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [CWIDTH-1:0]   width_q, width_d;
    logic [CWIDTH-1:0]   height_q, height_d;
    logic [CWIDTH-1:0]   num_frame_q, num_frame_d;
    logic [CWIDTH-1:0]   frame_count_q, frame_count_d;
    logic [CWIDTH-1:0]   rd_frame_q, rd_frame_d;
    logic [PWIDTH-1:0]   req_cnt_q, req_cnt_d;
    logic [CWIDTH-1:0]   x_q, x_d;
    logic [CWIDTH-1:0]   y_q, y_d;
    logic [1:0]          count_q, count_d;
    logic                rd_pending_q, rd_pending_d;
    logic [DWIDTH-1:0]   head_q, head_d;
    logic [DWIDTH-1:0]   tail_q, tail_d;
    logic                cfg_error_q, cfg_error_d;
    logic                done_q, done_d;

    logic [PWIDTH-1:0]   frame_px;
    logic [2:0]          occupancy;
    logic                pop;
    logic                at_eol;
    logic                at_eof;
    logic                final_frame;

    assign frame_px    = PWIDTH'(width_q) * PWIDTH'(height_q);
    assign out_valid   = (count_q != 2'd0);
    assign pop         = out_valid & out_ready;
    assign at_eol      = (x_q == width_q - CWIDTH'(1));
    assign at_eof      = at_eol & (y_q == height_q - CWIDTH'(1));
    assign final_frame = (num_frame_q != '0) & (rd_frame_q == num_frame_q - CWIDTH'(1));

    // Entries already held plus the one in flight, minus the one leaving now.
    assign occupancy   = 3'(count_q) + 3'(rd_pending_q) - 3'(pop);
    assign fifo_rdreq  = (state_q == STREAM) & ~fifo_empty & (occupancy < 3'd2)
                       & (req_cnt_q < frame_px);

    assign out_data    = head_q;
    assign out_sof     = out_valid & (x_q == '0) & (y_q == '0);
    assign out_eol     = out_valid & at_eol;
    assign out_eof     = out_valid & at_eof;
    assign busy        = (state_q != IDLE);
    assign frame_count = frame_count_q;
    assign cfg_error   = cfg_error_q;
    assign done        = done_q;

    always_comb begin
        // NOTE: every _d takes its _q value first so no path can infer a latch.
        state_d       = state_q;
        width_d       = width_q;
        height_d      = height_q;
        num_frame_d   = num_frame_q;
        frame_count_d = frame_count_q;
        rd_frame_d    = rd_frame_q;
        req_cnt_d     = req_cnt_q;
        x_d           = x_q;
        y_d           = y_q;
        count_d       = count_q;
        head_d        = head_q;
        tail_d        = tail_q;
        rd_pending_d  = fifo_rdreq;
        cfg_error_d   = 1'b0;
        done_d        = 1'b0;

        case ({rd_pending_q, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = fifo_q;
                else                 tail_d = fifo_q;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = fifo_q;
                end else begin
                    head_d = tail_q;
                    tail_d = fifo_q;
                end
            end
            default: ;
        endcase

        if (pop) begin
            if (at_eol) begin
                x_d = '0;
                if (at_eof) begin
                    y_d           = '0;
                    frame_count_d = frame_count_q + CWIDTH'(1);
                end else begin
                    y_d = y_q + CWIDTH'(1);
                end
            end else begin
                x_d = x_q + CWIDTH'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    if ((cfg_width == '0) || (cfg_height == '0)) begin
                        cfg_error_d = 1'b1;
                    end else begin
                        width_d       = cfg_width;
                        height_d      = cfg_height;
                        num_frame_d   = cfg_num_frame;
                        frame_count_d = '0;
                        rd_frame_d    = '0;
                        req_cnt_d     = '0;
                        x_d           = '0;
                        y_d           = '0;
                        state_d       = STREAM;
                    end
                end
            end
            STREAM: begin
                if (fifo_rdreq) begin
                    if (req_cnt_q + PWIDTH'(1) == frame_px) begin
                        req_cnt_d = '0;
                        if (final_frame) state_d = DRAIN;
                        else             rd_frame_d = rd_frame_q + CWIDTH'(1);
                    end else begin
                        req_cnt_d = req_cnt_q + PWIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                // All reads are issued, so the sole remaining entry is the final eof.
                if (pop && at_eof && (count_q == 2'd1) && !rd_pending_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the skid-buffer data registers are reset too, because out_data is
    // visible at the port and must read 0 after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            width_q       <= '0;
            height_q      <= '0;
            num_frame_q   <= '0;
            frame_count_q <= '0;
            rd_frame_q    <= '0;
            req_cnt_q     <= '0;
            x_q           <= '0;
            y_q           <= '0;
            count_q       <= '0;
            rd_pending_q  <= 1'b0;
            head_q        <= '0;
            tail_q        <= '0;
            cfg_error_q   <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q       <= state_d;
            width_q       <= width_d;
            height_q      <= height_d;
            num_frame_q   <= num_frame_d;
            frame_count_q <= frame_count_d;
            rd_frame_q    <= rd_frame_d;
            req_cnt_q     <= req_cnt_d;
            x_q           <= x_d;
            y_q           <= y_d;
            count_q       <= count_d;
            rd_pending_q  <= rd_pending_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            cfg_error_q   <= cfg_error_d;
            done_q        <= done_d;
        end
    end

endmodule

// File: tb/tb_vip_stream_source.sv
// Scoreboard bench for vip_stream_source: a FIFO model feeds the DUT, expected
// beats are queued at stimulus time and a negedge monitor pops and compares.
module tb_vip_stream_source;

    localparam int DW = 24;
    localparam int CW = 11;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sof;
        logic          eol;
        logic          eof;
    } beat_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          cfg_valid;
    logic [CW-1:0] cfg_width, cfg_height, cfg_num_frame;
    logic          cfg_error;
    logic          fifo_empty;
    logic [DW-1:0] fifo_q = '0;
    logic          fifo_rdreq;
    logic [DW-1:0] out_data;
    logic          out_valid, out_ready;
    logic          out_sof, out_eol, out_eof;
    logic          busy;
    logic [CW-1:0] frame_count;
    logic          done;

    vip_stream_source #(.DWIDTH(DW), .CWIDTH(CW)) dut (
        .clock(clock), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_num_frame(cfg_num_frame), .cfg_error(cfg_error),
        .fifo_empty(fifo_empty), .fifo_q(fifo_q), .fifo_rdreq(fifo_rdreq),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
        .busy(busy), .frame_count(frame_count), .done(done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_total = 0;
    int done_count = 0;
    int rd_cycles[$];
    int beat_cycles[$];
    logic [DW-1:0] fifo_mem[$];
    beat_t sb[$];
    logic empty_flag = 1'b1;
    logic empty_force = 1'b0;
    logic stall_prev = 1'b0;
    logic [DW+2:0] stall_val = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Normal-mode FIFO: data appears the cycle after rdreq.
    always @(posedge clock) begin
        if (fifo_rdreq) begin
            rd_total++;
            rd_cycles.push_back(cyc);
            check("fifo_read_nonempty", 32'(fifo_mem.size() != 0), 32'd1);
            if (fifo_mem.size() != 0) fifo_q <= fifo_mem.pop_front();
        end
    end

    always @(negedge clock) empty_flag = (fifo_mem.size() == 0);
    assign fifo_empty = empty_flag | empty_force;

    // Monitor: compare accepted beats against the scoreboard, check stall hold.
    always @(negedge clock) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (done) done_count++;
            if (stall_prev)
                check("stall_hold", 32'({out_valid, out_data, out_sof, out_eol, out_eof}),
                      32'({1'b1, stall_val}));
            if (out_valid && out_ready) begin
                beat_cycles.push_back(cyc);
                check("beat_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    beat_t e;
                    e = sb.pop_front();
                    check("beat_data", 32'(out_data), 32'(e.data));
                    check("beat_flags", 32'({out_sof, out_eol, out_eof}),
                          32'({e.sof, e.eol, e.eof}));
                end
            end
            stall_prev = out_valid & ~out_ready;
            stall_val  = {out_data, out_sof, out_eol, out_eof};
        end
    end

    task automatic load_fifo(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) fifo_mem.push_back(base + DW'(i));
    endtask

    task automatic expect_stream(input int w, input int h, input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            int pos, x, y;
            pos = i % (w * h);
            x = pos % w;
            y = pos / w;
            b.data = base + DW'(i);
            b.sof  = (x == 0) && (y == 0);
            b.eol  = (x == w - 1);
            b.eof  = (x == w - 1) && (y == h - 1);
            sb.push_back(b);
        end
    endtask

    task automatic apply_cfg(input int w, input int h, input int nf);
        @(posedge clock); #1;
        cfg_valid = 1'b1;
        cfg_width = CW'(w);
        cfg_height = CW'(h);
        cfg_num_frame = CW'(nf);
        @(posedge clock); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        int d0;
        int n;
        d0 = done_count;
        n = 0;
        while (done_count == d0 && n < budget) begin
            @(posedge clock); #1;
            if (rnd) begin
                out_ready = 1'($urandom_range(0, 1));
                empty_force = ($urandom_range(0, 3) == 0);
            end
            n++;
        end
        out_ready = 1'b1;
        empty_force = 1'b0;
        check("done_in_time", 32'(done_count - d0), 32'd1);
        @(posedge clock); #1;
    endtask

    task automatic wait_sb_empty(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clock); #1;
            n++;
        end
        check("sb_drained_in_time", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int r0;
        reset = 1'b1;
        cfg_valid = 1'b0;
        cfg_width = '0;
        cfg_height = '0;
        cfg_num_frame = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", 32'({fifo_rdreq, out_valid, out_sof, out_eol, out_eof,
                                   cfg_error, busy, done}), 32'd0);
        check("reset_data", 32'(out_data), 32'd0);
        check("reset_frame_count", 32'(frame_count), 32'd0);
        reset = 1'b0;

        // 4x2 single frame, full throughput.
        rd_cycles.delete();
        beat_cycles.delete();
        load_fifo(8, 24'h000001);
        expect_stream(4, 2, 8, 24'h000001);
        apply_cfg(4, 2, 1);
        check("busy_after_cfg", 32'(busy), 32'd1);
        wait_done(100, 1'b0);
        check("t1_rdreq_count", 32'(rd_cycles.size()), 32'd8);
        check("t1_beat_count", 32'(beat_cycles.size()), 32'd8);
        if (rd_cycles.size() == 8 && beat_cycles.size() == 8) begin
            check("t1_latency", 32'(beat_cycles[0] - rd_cycles[0]), 32'd2);
            check("t1_back_to_back", 32'(beat_cycles[7] - beat_cycles[0]), 32'd7);
        end
        check("t1_frame_count", 32'(frame_count), 32'd1);
        check("t1_idle", 32'(busy), 32'd0);

        // Same geometry with random back-pressure and FIFO starvation.
        r0 = rd_total;
        load_fifo(8, 24'h0000A0);
        expect_stream(4, 2, 8, 24'h0000A0);
        apply_cfg(4, 2, 1);
        wait_done(2000, 1'b1);
        check("t2_rdreq_count", 32'(rd_total - r0), 32'd8);
        check("t2_sb_empty", 32'(sb.size()), 32'd0);
        check("t2_frame_count", 32'(frame_count), 32'd1);

        // 3x3, two frames, FIFO over-filled.
        r0 = rd_total;
        load_fifo(20, 24'h000100);
        expect_stream(3, 3, 18, 24'h000100);
        apply_cfg(3, 3, 2);
        wait_done(200, 1'b0);
        check("t3_rdreq_count", 32'(rd_total - r0), 32'd18);
        check("t3_fifo_left", 32'(fifo_mem.size()), 32'd2);
        check("t3_frame_count", 32'(frame_count), 32'd2);
        check("t3_sb_empty", 32'(sb.size()), 32'd0);
        fifo_mem.delete();

        // Rejected geometry, then a 1x1 frame.
        @(posedge clock); #1;
        load_fifo(1, 24'hABCDEF);
        r0 = rd_total;
        apply_cfg(0, 3, 1);
        check("t4_cfg_error_pulse", 32'(cfg_error), 32'd1);
        check("t4_not_busy", 32'(busy), 32'd0);
        @(posedge clock); #1;
        check("t4_cfg_error_clear", 32'(cfg_error), 32'd0);
        repeat (3) @(posedge clock);
        #1;
        check("t4_no_rdreq", 32'(rd_total - r0), 32'd0);
        expect_stream(1, 1, 1, 24'hABCDEF);
        apply_cfg(1, 1, 1);
        wait_done(100, 1'b0);
        check("t4_frame_count", 32'(frame_count), 32'd1);

        // Continuous 2x2; a cfg while busy must be ignored.
        r0 = rd_total;
        load_fifo(10, 24'h000200);
        expect_stream(2, 2, 10, 24'h000200);
        apply_cfg(2, 2, 0);
        apply_cfg(1, 1, 1);
        wait_sb_empty(200);
        repeat (4) @(posedge clock);
        #1;
        check("t5_rdreq_count", 32'(rd_total - r0), 32'd10);
        check("t5_frame_count", 32'(frame_count), 32'd2);
        check("t5_still_busy", 32'(busy), 32'd1);
        check("t5_no_done", 32'(done_count), 32'd4);

        // Fill the skid buffer under back-pressure, then reset mid-frame.
        out_ready = 1'b0;
        r0 = rd_total;
        load_fifo(4, 24'h000300);
        repeat (8) @(posedge clock);
        #1;
        check("t6_two_reads", 32'(rd_total - r0), 32'd2);
        check("t6_valid_held", 32'(out_valid), 32'd1);
        check("t6_head_data", 32'(out_data), 32'h000300);
        reset = 1'b1;
        #1;
        check("t6_async_outputs", 32'({fifo_rdreq, out_valid, out_sof, out_eol, out_eof,
                                      cfg_error, busy, done}), 32'd0);
        check("t6_async_data", 32'(out_data), 32'd0);
        check("t6_async_frame_count", 32'(frame_count), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        fifo_mem.delete();
        sb.delete();
        out_ready = 1'b1;
        load_fifo(4, 24'h000400);
        expect_stream(2, 2, 4, 24'h000400);
        apply_cfg(2, 2, 1);
        wait_done(100, 1'b0);
        check("t6_frame_count", 32'(frame_count), 32'd1);
        check("t6_sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vip_stream_source.md
Name: vip_stream_source

Overview:
- Synthesizable FIFO-to-stream adapter. It sits directly downstream of the pixel FIFO filled by the image generator and reads 24-bit RGB pixels from that FIFO.
- Emits a valid/ready pixel stream with start-of-frame, end-of-line and end-of-frame markers, derived from run-time frame geometry.
- Feeds the first processing stage of the vip_core pipeline and decouples FIFO read latency from downstream back-pressure.

Parameters:
DWIDTH, 24, pixel width ({R,G,B}, 8 bits each)
CWIDTH, 11, width of geometry and frame-count fields

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
cfg_valid  in  1  one-cycle strobe: latch cfg_* and start streaming
cfg_width  in  CWIDTH  pixels per line
cfg_height  in  CWIDTH  lines per frame
cfg_num_frame  in  CWIDTH  frames to stream; 0 = continuous
cfg_error  out  1  one-cycle pulse: cfg rejected (width or height = 0)
fifo_empty  in  1  FIFO empty flag
fifo_q  in  DWIDTH  FIFO read data; normal mode, valid the cycle after rdreq
fifo_rdreq  out  1  FIFO read request
out_data  out  DWIDTH  pixel
out_valid  out  1  pixel valid
out_ready  in  1  downstream accept
out_sof  out  1  first pixel of frame (x=0, y=0)
out_eol  out  1  last pixel of line (x=width-1)
out_eof  out  1  last pixel of frame
busy  out  1  state != IDLE
frame_count  out  CWIDTH  frames fully emitted since last cfg_valid
done  out  1  one-cycle pulse when the last frame's eof is accepted

Behaviour:
- Reset (async) values: fifo_rdreq=0, out_valid=0, out_data=0, out_sof/eol/eof=0, cfg_error=0, busy=0, frame_count=0, done=0. Internal state: IDLE, buffer empty, all counters 0. FIFO contents are not touched.
- States:
  - IDLE: on cfg_valid with width≠0 and height≠0, latch width, height and num_frame, clear frame_count, then go to STREAM. If width or height = 0, pulse cfg_error the next cycle and stay in IDLE.
  - STREAM: reads FIFO and emits pixels. cfg_valid is ignored in this state. Goes to DRAIN after the last read request of the final frame.
  - DRAIN: no reads. Once the buffer is empty and the final eof has been accepted, pulse done and go to IDLE.
- Final frame: the final frame exists only when num_frame ≠ 0. With num_frame = 0, the block stays in STREAM indefinitely; only reset returns it to IDLE.
- Output buffer:
  - 2-entry skid buffer; out_* are driven from the head entry (registered).
  - rd_pending = fifo_rdreq registered one cycle.
  - pop = out_valid & out_ready.
- fifo_rdreq condition: asserted when state==STREAM & !fifo_empty & (count + rd_pending − pop < 2) & req_cnt < width*height.
  - The path from out_ready to fifo_rdreq is combinational by design. It is required for 1 pixel/cycle throughput.
- Latency: fifo_rdreq in cycle N → fifo_q captured at end of N+1 → out_valid in N+2 (empty buffer).
- req_cnt:
  - 22-bit counter of reads issued in the current frame; the product width*height is 22 bits unsigned.
  - On reaching width*height it resets to 0 and reading continues into the next frame, unless that frame was the final one.
  - The block never reads beyond the final frame.
- Output position counters x and y advance only on pop:
  - out_sof = (x==0 & y==0).
  - out_eol = (x==width−1).
  - out_eof = out_eol & (y==height−1).
  - On eol, x←0 and y←y+1. On eof, y←0 and frame_count increments (wraps at 2^CWIDTH).
- Back-pressure: while out_valid & !out_ready, out_data and the flags are held stable. The buffer never overflows and fifo_rdreq is never issued when the buffer cannot absorb the returning data.
- Simultaneous push (FIFO data return) and pop is legal; count is unchanged.
- fifo_empty: while it is asserted, no rdreq is issued; an already-pending read still completes.
- Degenerate geometry: width=1 gives sof, eol and eof all set on the same pixel when height=1.

Test Plan:
- cfg 4x2, num_frame=1, FIFO holds 8 pixels 0x000001..0x000008, out_ready=1 → 8 beats back-to-back starting 2 cycles after first rdreq; sof on beat 1, eol on beats 4 and 8, eof on beat 8; done pulse; frame_count=1; exactly 8 rdreq.
- Same cfg, out_ready toggled pseudo-randomly, fifo_empty randomly asserted → identical data/flag sequence, no lost or duplicated pixels, data held stable while stalled.
- cfg 3x3, num_frame=2, FIFO holds 20 pixels → exactly 18 reads, 2 eof, frame_count=2, done pulse; 2 pixels remain in the FIFO.
- cfg_width=0 → cfg_error pulse, busy stays 0, no rdreq; then a valid cfg 1x1 → single beat with sof=eol=eof=1.
- num_frame=0, cfg 2x2 → continuous streaming; frame_count increments every 4 accepted beats; cfg_valid while busy is ignored.
- Reset asserted mid-frame with the buffer full → all outputs 0 immediately; after deassertion, a new cfg restarts with sof on the first beat.
